event_input_fifo: RTL

- Upstream ingress stage that buffers raw sensor events (x, y, p, t; 2 bits each) from the pixel-array interface.
- Presents events one at a time, in order, to the event-based denoising filter.
- Decouples bursty sensor traffic from the filter's one-event-per-clock consumption.
- Counts and flags events dropped on overflow.
- When no event is valid, drives p = 2'b00 so the downstream filter outputs zeros.

---
 rtl/event_input_fifo.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/event_input_fifo.sv
// Ingress FIFO for raw sensor events {x,y,p,t}, with a registered output stage and overflow accounting.
// Optional EVENT_DEDUP_EN drops an incoming event identical to the last accepted one.
module event_input_fifo #(
   parameter int DEPTH      = 8,
   parameter int DROP_CNT_W = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     in_valid,
   input  logic [1:0]               in_x,
   input  logic [1:0]               in_y,
   input  logic [1:0]               in_p,
   input  logic [1:0]               in_t,
   output logic                     in_ready,
   input  logic                     out_ready,
   output logic                     out_valid,
   output logic [1:0]               out_x,
   output logic [1:0]               out_y,
   output logic [1:0]               out_p,
   output logic [1:0]               out_t,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     overflow,
   output logic [DROP_CNT_W-1:0]    drop_count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

   logic [7:0]            mem_q [DEPTH];
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [AW:0]           level_q, level_d;
   logic                  out_valid_q, out_valid_d;
   logic [7:0]            out_data_q, out_data_d;
   logic                  overflow_q, overflow_d;
   logic [DROP_CNT_W-1:0] drop_count_q, drop_count_d;

   logic [7:0] in_entry;
   logic       dup;
   logic       push;
   logic       drop;
   logic       load;
   logic       clear;

   assign in_entry = {in_x, in_y, in_p, in_t};

`ifdef EVENT_DEDUP_EN
   logic [8:0] last_q, last_d;

   assign dup = last_q[8] && (last_q[7:0] == in_entry);

   always_comb begin
      last_d = last_q;
      if (push) begin
         last_d = {1'b1, in_entry};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q <= '0;
      end else begin
         last_q <= last_d;
      end
   end
`else
   assign dup = 1'b0;
`endif

   // Refusal while full holds even when the output register drains in the same cycle.
   always_comb begin
      in_ready = (level_q != FULL_LEVEL);
      push     = in_valid && in_ready && !dup;
      drop     = in_valid && !in_ready && !dup;
      load     = (level_q != '0) && (!out_valid_q || out_ready);
      clear    = out_valid_q && out_ready && (level_q == '0);
   end

   always_comb begin
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      level_d      = level_q;
      out_valid_d  = out_valid_q;
      out_data_d   = out_data_q;
      overflow_d   = overflow_q | drop;
      drop_count_d = drop_count_q;

      if (push) begin
         wr_ptr_d = wr_ptr_q + 1'b1;
      end
      if (load) begin
         rd_ptr_d    = rd_ptr_q + 1'b1;
         out_valid_d = 1'b1;
         out_data_d  = mem_q[rd_ptr_q];
      end else if (clear) begin
         out_valid_d = 1'b0;
         out_data_d  = '0;
      end

      case ({push, load})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase

      if (drop && (drop_count_q != '1)) begin
         drop_count_d = drop_count_q + 1'b1;
      end
   end

   // Storage array carries no reset; only entries behind the write pointer are ever read.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= in_entry;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         level_q      <= '0;
         out_valid_q  <= 1'b0;
         out_data_q   <= '0;
         overflow_q   <= 1'b0;
         drop_count_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         level_q      <= level_d;
         out_valid_q  <= out_valid_d;
         out_data_q   <= out_data_d;
         overflow_q   <= overflow_d;
         drop_count_q <= drop_count_d;
      end
   end

   assign out_valid  = out_valid_q;
   assign out_x      = out_data_q[7:6];
   assign out_y      = out_data_q[5:4];
   assign out_p      = out_data_q[3:2];
   assign out_t      = out_data_q[1:0];
   assign level      = level_q;
   assign overflow   = overflow_q;
   assign drop_count = drop_count_q;

endmodule
